// File: rtl/sram_port_pkg.sv
// Shared definitions for the two-port SRAM server.
// Holds the read-tag constants, the default widths and latency, the arbiter
// pointer encoding, and a saturating counter increment.
package sram_port_pkg;

   localparam int DEF_ADDRESS_WIDTH   = 32;
   localparam int DEF_SRAMDATA_WIDTH  = 32;
   localparam int DEF_TAG_WIDTH       = 2;
   localparam int DEF_SRAM_ADDR_WIDTH = 20;
   localparam int DEF_READ_LATENCY    = 2;

   localparam logic [1:0] INVALID_TAG  = 2'd0;
   localparam logic [1:0] DATA_TAG0    = 2'd1;
   localparam logic [1:0] DATA_TAG1    = 2'd2;
   localparam logic [1:0] DATA_END_TAG = 2'd3;

   // Remembers which port won the most recent grant.
   typedef enum logic {
      LAST_PORT0 = 1'b0,
      LAST_PORT1 = 1'b1
   } arb_last_e;

   function automatic logic [31:0] sat_inc(input logic [31:0] value);
      return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
   endfunction

endpackage

// File: rtl/sram_read_pipe.sv
// Read-response delay line for the SRAM server.
// Carries valid, tag and out-of-range flag for every accepted read so that
// they line up with the SRAM read data DEPTH cycles after the address phase.
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   in_valid/in_tag/in_oor     stage-0 inputs (accepted read this cycle)
//   out_valid/out_tag/out_oor  last stage, aligned with sram_rdata
module sram_read_pipe #(
   parameter int TAG_WIDTH = 2,
   parameter int DEPTH     = 3
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 in_valid,
   input  logic [TAG_WIDTH-1:0] in_tag,
   input  logic                 in_oor,
   output logic                 out_valid,
   output logic [TAG_WIDTH-1:0] out_tag,
   output logic                 out_oor
);

   logic [DEPTH-1:0]     valid_q;
   logic [DEPTH-1:0]     oor_q;
   logic [TAG_WIDTH-1:0] tag_q [DEPTH];

   always_ff @(posedge clock) begin
      if (reset) begin
         valid_q <= '0;
         oor_q   <= '0;
         for (int i = 0; i < DEPTH; i++) tag_q[i] <= '0;
      end else begin
         valid_q[0] <= in_valid;
         oor_q[0]   <= in_oor;
         tag_q[0]   <= in_tag;
         for (int i = 1; i < DEPTH; i++) begin
            valid_q[i] <= valid_q[i-1];
            oor_q[i]   <= oor_q[i-1];
            tag_q[i]   <= tag_q[i-1];
         end
      end
   end

   assign out_valid = valid_q[DEPTH-1];
   assign out_oor   = oor_q[DEPTH-1];
   assign out_tag   = tag_q[DEPTH-1];

endmodule

// File: rtl/sram_port_server.sv
// Two-port single-SRAM server: port 0 reads, port 1 writes.
// A grant (ready) in one cycle entitles the port to one command slot in the
// next cycle; accepted commands drive the SRAM one cycle later and reads
// return valid0/query0/qtag0 READ_LATENCY+2 cycles after acceptance.
// Ports:
//   clock, reset                    clock, synchronous active-high reset
//   request0/1, ready0/1            service request and one-cycle grant
//   command_entry0/1, write_enable1 command strobes within a granted slot
//   address0/1, tag0, data_out1     command payload
//   valid0, query0, qtag0           read response
//   sram_addr/we/wdata/rdata        physical SRAM port
//   rd_count, wr_count              saturating accepted-command counters
//   addr_error, cmd_error           sticky error flags
//
// Arbiter pointer (last_q):
//   state      | meaning
//   LAST_PORT0 | port 0 granted last; port 1 wins a tie
//   LAST_PORT1 | port 1 granted last (or reset); port 0 wins a tie
module sram_port_server
   import sram_port_pkg::*;
#(
   parameter int ADDRESS_WIDTH   = DEF_ADDRESS_WIDTH,
   parameter int SRAMDATA_WIDTH  = DEF_SRAMDATA_WIDTH,
   parameter int TAG_WIDTH       = DEF_TAG_WIDTH,
   parameter int SRAM_ADDR_WIDTH = DEF_SRAM_ADDR_WIDTH,
   parameter int READ_LATENCY    = DEF_READ_LATENCY
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       request0,
   input  logic                       request1,
   input  logic                       command_entry0,
   input  logic                       command_entry1,
   input  logic                       write_enable1,
   input  logic [ADDRESS_WIDTH-1:0]   address0,
   input  logic [ADDRESS_WIDTH-1:0]   address1,
   input  logic [TAG_WIDTH-1:0]       tag0,
   input  logic [SRAMDATA_WIDTH-1:0]  data_out1,
   output logic                       ready0,
   output logic                       ready1,
   output logic                       valid0,
   output logic [SRAMDATA_WIDTH-1:0]  query0,
   output logic [TAG_WIDTH-1:0]       qtag0,
   output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
   output logic                       sram_we,
   output logic [SRAMDATA_WIDTH-1:0]  sram_wdata,
   input  logic [SRAMDATA_WIDTH-1:0]  sram_rdata,
   output logic [31:0]                rd_count,
   output logic [31:0]                wr_count,
   output logic                       addr_error,
   output logic                       cmd_error
);

   // Address bits that must be zero for a physically reachable word.
   localparam logic [ADDRESS_WIDTH-1:0] HI_MASK =
      ADDRESS_WIDTH'({64{1'b1}} << SRAM_ADDR_WIDTH);

   arb_last_e last_q;
   logic      slot0_q;
   logic      slot1_q;
   logic      rd_acc;
   logic      wr_acc;
   logic      rd_oor;
   logic      wr_oor;

   logic                 pipe_valid;
   logic                 pipe_oor;
   logic [TAG_WIDTH-1:0] pipe_tag;

   assign rd_acc = slot0_q & command_entry0;
   assign wr_acc = slot1_q & command_entry1 & write_enable1;
   assign rd_oor = |(address0 & HI_MASK);
   assign wr_oor = |(address1 & HI_MASK);

   // Grant is combinational so it can only follow a request present in the
   // same cycle; reset forces both grants low.
   always_comb begin
      ready0 = 1'b0;
      ready1 = 1'b0;
      if (!reset) begin
         if (request0 && request1) begin
            ready0 = (last_q == LAST_PORT1);
            ready1 = (last_q == LAST_PORT0);
         end else begin
            ready0 = request0;
            ready1 = request1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         last_q     <= LAST_PORT1;
         slot0_q    <= 1'b0;
         slot1_q    <= 1'b0;
         sram_we    <= 1'b0;
         sram_addr  <= '0;
         sram_wdata <= '0;
         rd_count   <= '0;
         wr_count   <= '0;
         addr_error <= 1'b0;
         cmd_error  <= 1'b0;
         valid0     <= 1'b0;
         query0     <= '0;
         qtag0      <= '0;
      end else begin
         slot0_q <= ready0;
         slot1_q <= ready1;
         if (ready0)      last_q <= LAST_PORT0;
         else if (ready1) last_q <= LAST_PORT1;

         // Out-of-range writes are counted and flagged but never strobe we.
         sram_we <= wr_acc & ~wr_oor;
         if (rd_acc)      sram_addr <= address0[SRAM_ADDR_WIDTH-1:0];
         else if (wr_acc) sram_addr <= address1[SRAM_ADDR_WIDTH-1:0];
         if (wr_acc && !wr_oor) sram_wdata <= data_out1;

         if (rd_acc) rd_count <= sat_inc(rd_count);
         if (wr_acc) wr_count <= sat_inc(wr_count);
         if ((rd_acc && rd_oor) || (wr_acc && wr_oor)) addr_error <= 1'b1;
         if ((command_entry0 && !slot0_q) || (command_entry1 && !slot1_q))
            cmd_error <= 1'b1;

         valid0 <= pipe_valid;
         query0 <= (pipe_valid && !pipe_oor) ? sram_rdata : '0;
         qtag0  <= pipe_valid ? pipe_tag : '0;
      end
   end

   // One stage for the address register plus READ_LATENCY SRAM cycles.
   sram_read_pipe #(
      .TAG_WIDTH (TAG_WIDTH),
      .DEPTH     (READ_LATENCY + 1)
   ) u_read_pipe (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (rd_acc),
      .in_tag    (tag0),
      .in_oor    (rd_oor),
      .out_valid (pipe_valid),
      .out_tag   (pipe_tag),
      .out_oor   (pipe_oor)
   );

endmodule
